// File: rtl/alu_result_packer.sv
// ALU result packer: selects the active ALU result class, queues it in a small FIFO and
// streams each entry out as OUT_WIDTH-bit beats with tag/carry sideband.
module alu_result_packer #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           In_Valid,
  input  logic [A_WIDTH+B_WIDTH-1:0]     Arith_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0]     Logic_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0]     CMP_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0]     Shift_OUT,
  input  logic                           Carry_OUT,
  input  logic                           Arith_Flag,
  input  logic                           Logic_Flag,
  input  logic                           CMP_Flag,
  input  logic                           Shift_Flag,
  input  logic                           Out_Ready,
  input  logic                           Clear_Err,
  output logic [OUT_WIDTH-1:0]           Out_Data,
  output logic                           Out_Valid,
  output logic                           Out_Last,
  output logic [1:0]                     Out_Tag,
  output logic                           Out_Carry,
  output logic [$clog2(DEPTH):0]         Fifo_Count,
  output logic                           Fifo_Full,
  output logic                           Overflow_Err
);

  localparam int unsigned RES_WIDTH = A_WIDTH + B_WIDTH;
  localparam int unsigned BEATS     = RES_WIDTH / OUT_WIDTH;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [RES_WIDTH-1:0] res_mem   [DEPTH];
  logic [1:0]           tag_mem   [DEPTH];
  logic                 carry_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic [RES_WIDTH-1:0] sel_res, head_res;
  logic [1:0]           sel_tag;
  logic                 sel_carry;
  logic                 push_req, full, valid, last_beat, xfer, pop, accept;

  // Priority: arith > logic > cmp > shift; carry only travels with arith results.
  always_comb begin
    sel_tag   = 2'b00;
    sel_res   = Arith_OUT;
    sel_carry = Carry_OUT;
    if (!Arith_Flag) begin
      sel_carry = 1'b0;
      if (Logic_Flag) begin
        sel_tag = 2'b01;
        sel_res = Logic_OUT;
      end else if (CMP_Flag) begin
        sel_tag = 2'b10;
        sel_res = CMP_OUT;
      end else begin
        sel_tag = 2'b11;
        sel_res = Shift_OUT;
      end
    end
  end

  assign push_req  = In_Valid & (Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign valid     = (count_q != '0);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign xfer      = valid & Out_Ready;
  assign pop       = xfer & last_beat;
  // When full, a same-cycle pop frees the slot the write pointer is aimed at.
  assign accept    = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;
    err_d    = err_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (xfer) beat_d = last_beat ? '0 : beat_q + 1'b1;
    if (push_req && full && !pop) begin
      err_d = 1'b1;
    end else if (Clear_Err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (accept) begin
      res_mem[wr_ptr_q]   <= sel_res;
      tag_mem[wr_ptr_q]   <= sel_tag;
      carry_mem[wr_ptr_q] <= sel_carry;
    end
  end

  assign head_res = res_mem[rd_ptr_q];

  always_comb begin
    Out_Data  = '0;
    Out_Tag   = 2'b00;
    Out_Carry = 1'b0;
    if (valid) begin
      Out_Data  = head_res[beat_q * OUT_WIDTH +: OUT_WIDTH];
      Out_Tag   = tag_mem[rd_ptr_q];
      Out_Carry = carry_mem[rd_ptr_q];
    end
  end

  assign Out_Valid    = valid;
  assign Out_Last     = valid & last_beat;
  assign Fifo_Count   = count_q;
  assign Fifo_Full    = full;
  assign Overflow_Err = err_q;

endmodule
